// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor: computes |x - y| and a sign flag, one digit per clock,
// framed by a start/busy/done handshake.
module bcd_subtractor_seq #(
    parameter int NDIG = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   x,
    input  logic [4*NDIG-1:0]   y,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   z,
    output logic                neg,
    output logic                err
);
    localparam int W  = 4 * NDIG;
    localparam int IW = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_CMP, S_FIN} state_t;

    state_t          r_state;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    r_res;
    logic            r_borrow;
    logic [IW-1:0]   r_idx;

    logic [3:0]      w_a;
    logic [3:0]      w_b;
    logic [4:0]      w_diff;
    logic            w_bout;
    logic [3:0]      w_dig;
    logic [W-1:0]    w_res;
    logic            w_last;

    function automatic logic all_bcd(input logic [W-1:0] v);
        all_bcd = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                all_bcd = 1'b0;
            end
        end
    endfunction

    // One digit step: SUB takes x_i - y_i, CMP takes 0 - r_i (ten's complement pass).
    always_comb begin
        w_a = 4'd0;
        w_b = 4'd0;
        if (r_state == S_SUB) begin
            w_a = r_x[4*r_idx +: 4];
            w_b = r_y[4*r_idx +: 4];
        end else begin
            w_a = 4'd0;
            w_b = r_res[4*r_idx +: 4];
        end
        w_diff = {1'b0, w_a} - {1'b0, w_b} - {4'd0, r_borrow};
        w_bout = w_diff[4];
        w_dig  = w_bout ? (w_diff[3:0] + 4'd10) : w_diff[3:0];
        w_res  = r_res;
        w_res[4*r_idx +: 4] = w_dig;
        w_last = (r_idx == IW'(NDIG - 1));
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            z        <= '0;
            neg      <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x      <= x;
                        r_y      <= y;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                        if (!all_bcd(x) || !all_bcd(y)) begin
                            z       <= '0;
                            neg     <= 1'b0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            busy    <= 1'b1;
                            r_state <= S_SUB;
                        end
                    end
                end
                S_SUB: begin
                    r_res <= w_res;
                    if (w_last && w_bout) begin
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                        r_state  <= S_CMP;
                    end else if (w_last) begin
                        z       <= w_res;
                        neg     <= 1'b0;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_borrow <= w_bout;
                        r_idx    <= r_idx + IW'(1);
                    end
                end
                S_CMP: begin
                    r_res <= w_res;
                    if (w_last) begin
                        z       <= w_res;
                        neg     <= 1'b1;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_borrow <= w_bout;
                        r_idx    <= r_idx + IW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Scoreboard bench for bcd_subtractor_seq: a driver pushes decimal-model expectations,
// a negedge monitor pops them on every done pulse and checks that outputs hold in between.
module tb_bcd_subtractor_seq;
    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] z;
    logic         neg;
    logic         err;

    bcd_subtractor_seq #(.NDIG(NDIG)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .z(z), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z;
        logic         neg;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] h_z = '0;
    logic         h_neg = 1'b0;
    logic         h_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digit values -> integers, subtract, split magnitude back to digits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        exp_t e;
        int   av = 0;
        int   bv = 0;
        int   m;
        logic bad = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (int'(a[4*i +: 4]) > 9 || int'(b[4*i +: 4]) > 9) bad = 1'b1;
            av = av * 10 + int'(a[4*i +: 4]);
            bv = bv * 10 + int'(b[4*i +: 4]);
        end
        e.z = '0;
        if (bad) begin
            e.neg = 1'b0;
            e.err = 1'b1;
            e.cyc = c + 1;
        end else begin
            m     = av - bv;
            e.neg = (m < 0);
            e.err = 1'b0;
            if (m < 0) m = -m;
            for (int i = 0; i < NDIG; i++) begin
                e.z[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
            e.cyc = c + (e.neg ? 2 * NDIG + 1 : NDIG + 1);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        int           k;
        for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, NDIG - 1);
            v[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    // Monitor: pop and compare at each done, otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            h_z = '0; h_neg = 1'b0; h_err = 1'b0;
        end else if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("z", 32'(z), 32'(e.z));
                chk("neg", 32'(neg), 32'(e.neg));
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                h_z = e.z; h_neg = e.neg; h_err = e.err;
            end
        end else begin
            chk("hold", 32'({z, neg, err}), 32'({h_z, h_neg, h_err}));
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        q.push_back(model(a, b, cyc));
        x = a;
        y = b;
        start = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk); #1;
        issue(a, b);
        @(negedge clk); #1;
        start = 1'b0;
        drain();
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #1 rst = 1'b0;

        // 52 - 27 with busy profile
        @(negedge clk); #1;
        issue(8'h52, 8'h27);
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_c1", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("busy_c2", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("busy_c3", 32'(busy), 32'd0);
        drain();

        run_op(8'h27, 8'h52);
        run_op(8'h00, 8'h99);
        run_op(8'h99, 8'h99);
        run_op(8'h3A, 8'h10);
        run_op(8'h45, 8'h12);

        // start held through every busy cycle of a 27-52 operation
        @(negedge clk); #1;
        issue(8'h27, 8'h52);
        repeat (5) @(negedge clk);
        #1 start = 1'b0;
        drain();

        // asynchronous reset during CMP
        @(negedge clk); #1;
        issue(8'h27, 8'h52);
        @(negedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_z", 32'(z), 32'd0);
        chk("arst_neg", 32'(neg), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        run_op(8'h10, 8'h01);

        // back-to-back with start held high
        @(negedge clk); #1;
        c = cyc;
        for (int k = 0; k < 4; k++) q.push_back(model(8'h80, 8'h08, c + 4 * k));
        x = 8'h80;
        y = 8'h08;
        start = 1'b1;
        begin
            int n = 0;
            while (q.size() != 0 && n < 60) begin
                @(negedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        chk("b2b_timeout", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clk); #1;

        repeat (40) run_op(rand_opnd(), rand_opnd());

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_subtractor_seq.md
Name: bcd_subtractor_seq

Overview:
Digit-serial packed-BCD subtractor. It computes |x - y| and a sign flag for two NDIG-digit BCD operands, processing one digit per clock. It is the inverse companion of the team's combinational 2-digit BCD adder and is used wherever a decimal difference or decimal comparison is needed. A start/busy/done handshake frames each operation.

Parameters:
NDIG, 2, number of BCD digits per operand (>=1); operand width W = 4*NDIG.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
start  input  1  request; sampled only in IDLE.
x  input  W  minuend, packed BCD, digit 0 in bits [3:0].
y  input  W  subtrahend, packed BCD.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when z, neg and err are valid.
z  output  W  magnitude |x - y| in packed BCD; held until the next completion.
neg  output  1  1 when x < y; held with z.
err  output  1  1 when an operand digit is greater than 9; held with z.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, z=0, neg=0, err=0; internal registers are 0.
- States: IDLE, SUB, CMP, FIN.
- IDLE:
  - On start=1 at a rising edge, latch x and y into operand registers, clear borrow, set digit index i=0.
  - Validity check on the latched operands: if any nibble of x or y is >9, go to FIN with err_next=1 and z_next=0. Otherwise go to SUB.
  - start is ignored in every state other than IDLE.
- SUB (NDIG cycles, one per digit i = 0..NDIG-1):
  - d = x_i - y_i - borrow, computed in 5-bit signed arithmetic.
  - If d < 0: r_i = d + 10 and borrow = 1. Otherwise r_i = d and borrow = 0.
  - After digit NDIG-1: if final borrow = 0, go to FIN with neg_next=0. If final borrow = 1, clear borrow, set i=0 and go to CMP.
- CMP (NDIG cycles): replaces r with its ten's complement, digit by digit.
  - Each digit: d = 0 - r_i - borrow, with the same correction rule as SUB.
  - After digit NDIG-1, go to FIN with neg_next=1.
- FIN (1 cycle):
  - z, neg and err are loaded from the result registers at the entry edge.
  - done=1 for exactly this cycle; busy=0 in this cycle.
  - Next state is IDLE.
- busy is 1 in SUB and CMP and 0 otherwise.
- Latency, counted from the edge that samples start to the first cycle with done high:
  - x >= y: NDIG+1 cycles.
  - x < y: 2*NDIG+1 cycles.
  - err: 1 cycle.
- Output stability: z, neg and err change only at FIN entry or on reset. Between operations they hold their last values.
- Boundaries:
  - x == y gives z=0, neg=0.
  - 0 - (10^NDIG - 1) gives z = all 9s, neg=1.
  - A start held high through FIN is not accepted until the cycle after FIN, when the block is back in IDLE. It is then accepted as a new operation.
- Reset mid-operation: immediate return to IDLE with every output at its reset value. The partial result is discarded.
- Digit-count wrap: the index counter is ceil(log2(NDIG))+1 bits wide and never wraps within a phase.

Test Plan:
- NDIG=2. Reset, then start with x=0x52, y=0x27 -> after 3 cycles done=1 for one cycle, z=0x25, neg=0, err=0. busy=1 on cycles 1-2.
- x=0x27, y=0x52 -> done after 5 cycles, z=0x25, neg=1. x=0x00, y=0x99 -> z=0x99, neg=1. x=0x99, y=0x99 -> z=0x00, neg=0, done after 3 cycles.
- x=0x3A, y=0x10 -> done after 1 cycle, err=1, z=0x00, neg=0. A following start with valid operands clears err at its own done.
- Start pulsed again on each busy cycle of a 27-52 operation -> the extra pulses are ignored, exactly one done, result z=0x25, neg=1.
- Assert rst asynchronously between clock edges during CMP -> busy, done, z, neg and err go to 0 immediately, without waiting for an edge. After release, a start with x=0x10, y=0x01 -> z=0x09, neg=0.
- Back-to-back: hold start high continuously with x=0x80, y=0x08 -> done pulses every 4 cycles, each time with z=0x72. z stays stable between pulses.
